// File: rtl/lsu_stall_bridge.sv
`default_nettype none
// ============================================================================
// Module : lsu_stall_bridge
// Brief  : Registered, handshaked load/store bus master with size/extension
//          handling, misalignment detection, ack timeout and core stall.
// Rev    : 1.0  initial release
// ============================================================================
module lsu_stall_bridge #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                cpu_clk,
    input  logic                cpu_rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic [1:0]          resp_err,
    output logic                stall,
    output logic                Bus_req,
    output logic                Bus_we,
    output logic [ADDR_W-1:0]   Bus_addr,
    output logic [DATA_W/8-1:0] Bus_wstrb,
    output logic [DATA_W-1:0]   Bus_wdata,
    input  logic [DATA_W-1:0]   Bus_rdata,
    input  logic                Bus_ack
);

    localparam int c_nbytes = DATA_W / 8;
    localparam int c_off_w  = $clog2(c_nbytes);
    localparam int c_cnt_w  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_bus  = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    localparam logic [1:0] c_err_ok    = 2'b00;
    localparam logic [1:0] c_err_align = 2'b01;
    localparam logic [1:0] c_err_tmo   = 2'b10;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_we;
    logic                r_unsigned;
    logic [1:0]          r_size;
    logic [c_off_w-1:0]  r_off;
    logic                r_bus_req;
    logic                r_bus_we;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [c_nbytes-1:0] r_bus_wstrb;
    logic [DATA_W-1:0]   r_bus_wdata;
    logic [1:0]          r_resp_err;
    logic [DATA_W-1:0]   r_resp_rdata;

    logic [c_off_w-1:0]  w_off;
    logic                w_bad;
    logic                w_timeout;
    logic [c_nbytes-1:0] w_strb;
    logic [DATA_W-1:0]   w_wdata_rep;
    logic [DATA_W-1:0]   w_shifted;
    logic [DATA_W-1:0]   w_lane_mask;
    logic [DATA_W-1:0]   w_load;
    logic                w_sign;

    assign w_off     = req_addr[c_off_w-1:0];
    assign w_timeout = (r_cnt == c_cnt_w'(TIMEOUT_CYC - 1));

    always_comb begin
        w_bad = 1'b0;
        case (req_size)
            2'b01:   w_bad = req_addr[0];
            2'b10:   w_bad = |req_addr[1:0];
            2'b11:   w_bad = (DATA_W != 64) || (|req_addr[2:0]);
            default: w_bad = 1'b0;
        endcase
    end

    // Store lanes: strobes shifted to the byte offset, data replicated to every lane.
    always_comb begin
        w_strb      = '0;
        w_wdata_rep = '0;
        case (req_size)
            2'b00: begin
                w_strb      = c_nbytes'(1) << w_off;
                w_wdata_rep = {c_nbytes{req_wdata[7:0]}};
            end
            2'b01: begin
                w_strb      = c_nbytes'(3) << w_off;
                w_wdata_rep = {(c_nbytes/2){req_wdata[15:0]}};
            end
            2'b10: begin
                w_strb      = c_nbytes'(15) << w_off;
                w_wdata_rep = {(c_nbytes/4){req_wdata[31:0]}};
            end
            default: begin
                w_strb      = '1;
                w_wdata_rep = req_wdata;
            end
        endcase
        if (!req_we) begin
            w_strb      = '0;
            w_wdata_rep = '0;
        end
    end

    assign w_shifted = Bus_rdata >> {r_off, 3'b000};

    always_comb begin
        w_lane_mask = '1;
        w_sign      = 1'b0;
        case (r_size)
            2'b00: begin
                w_lane_mask = DATA_W'(8'hFF);
                w_sign      = w_shifted[7];
            end
            2'b01: begin
                w_lane_mask = DATA_W'(16'hFFFF);
                w_sign      = w_shifted[15];
            end
            2'b10: begin
                w_lane_mask = DATA_W'(32'hFFFF_FFFF);
                w_sign      = w_shifted[31];
            end
            default: begin
                w_lane_mask = '1;
                w_sign      = 1'b0;
            end
        endcase
        w_load = w_shifted & w_lane_mask;
        if (w_sign && !r_unsigned) begin
            w_load = w_load | ~w_lane_mask;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (req_valid) w_state_nxt = w_bad ? c_st_resp : c_st_bus;
            c_st_bus:  if (Bus_ack || w_timeout) w_state_nxt = c_st_resp;
            c_st_resp: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst) begin
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_unsigned   <= 1'b0;
            r_size       <= 2'b00;
            r_off        <= '0;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_wstrb  <= '0;
            r_bus_wdata  <= '0;
            r_resp_err   <= c_err_ok;
            r_resp_rdata <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (req_valid) begin
                        r_we         <= req_we;
                        r_unsigned   <= req_unsigned;
                        r_size       <= req_size;
                        r_off        <= w_off;
                        r_cnt        <= '0;
                        r_resp_rdata <= '0;
                        if (w_bad) begin
                            r_resp_err <= c_err_align;
                        end else begin
                            r_resp_err  <= c_err_ok;
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= req_we;
                            r_bus_addr  <= {req_addr[ADDR_W-1:c_off_w], c_off_w'(0)};
                            r_bus_wstrb <= w_strb;
                            r_bus_wdata <= w_wdata_rep;
                        end
                    end
                end
                c_st_bus: begin
                    // Ack takes priority over a coincident timeout.
                    if (Bus_ack || w_timeout) begin
                        r_bus_req    <= 1'b0;
                        r_bus_we     <= 1'b0;
                        r_bus_addr   <= '0;
                        r_bus_wstrb  <= '0;
                        r_bus_wdata  <= '0;
                        r_resp_err   <= Bus_ack ? c_err_ok : c_err_tmo;
                        r_resp_rdata <= (Bus_ack && !r_we) ? w_load : '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready  = (r_state == c_st_idle);
    assign stall      = (r_state != c_st_idle);
    assign resp_valid = (r_state == c_st_resp);
    assign resp_rdata = resp_valid ? r_resp_rdata : '0;
    assign resp_err   = resp_valid ? r_resp_err : c_err_ok;
    assign Bus_req    = r_bus_req;
    assign Bus_we     = r_bus_we;
    assign Bus_addr   = r_bus_addr;
    assign Bus_wstrb  = r_bus_wstrb;
    assign Bus_wdata  = r_bus_wdata;

endmodule
`default_nettype wire
